// File: rtl/tdec_wrap_out_sched.sv
// Output scheduler for the turbo-decoder wrapper byte FIFO: prepends the length
// header, admits upstream bytes under almost-full backpressure and drains to a valid/ready stream.
module tdec_wrap_out_sched #(
   parameter int unsigned LEN_W  = 16,
   parameter bit          HDR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] blk_len,
   input  logic             abort,
   input  logic             src_vld,
   input  logic [7:0]       src_data,
   output logic             src_rdy,
   output logic             fifo_wr_en,
   output logic [7:0]       fifo_wr_data,
   output logic             fifo_rd_en,
   input  logic [7:0]       fifo_rd_data,
   input  logic             fifo_empty,
   input  logic             fifo_almost_full,
   output logic             fifo_flush,
   output logic             out_vld,
   output logic [7:0]       out_data,
   output logic             out_last,
   input  logic             out_rdy,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN, S_DONE} state_t;

   localparam logic [LEN_W:0] ONE       = (LEN_W+1)'(1);
   localparam logic [LEN_W:0] HDR_BYTES = HDR_EN ? (LEN_W+1)'(2) : '0;

   state_t           state, state_nx;
   logic [LEN_W-1:0] len_q, len_nx;
   logic [LEN_W:0]   total_q, total_nx;
   logic [LEN_W:0]   wr_cnt, wr_cnt_nx;
   logic [LEN_W:0]   rd_cnt, rd_cnt_nx;
   logic             hdr_idx, hdr_idx_nx;
   logic [15:0]      hdr_word;
   logic             rd_side;

   // Header is always two bytes; narrower lengths are zero-extended.
   generate
      if (LEN_W >= 16) begin : g_hdr_wide
         assign hdr_word = len_q[15:0];
      end else begin : g_hdr_narrow
         assign hdr_word = {{(16-LEN_W){1'b0}}, len_q};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         len_q   <= '0;
         total_q <= '0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         hdr_idx <= 1'b0;
      end else begin
         state   <= state_nx;
         len_q   <= len_nx;
         total_q <= total_nx;
         wr_cnt  <= wr_cnt_nx;
         rd_cnt  <= rd_cnt_nx;
         hdr_idx <= hdr_idx_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      len_nx       = len_q;
      total_nx     = total_q;
      wr_cnt_nx    = wr_cnt;
      rd_cnt_nx    = rd_cnt;
      hdr_idx_nx   = hdr_idx;
      src_rdy      = 1'b0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      fifo_rd_en   = 1'b0;
      fifo_flush   = 1'b0;
      out_vld      = 1'b0;
      out_data     = '0;
      out_last     = 1'b0;
      done         = 1'b0;
      busy         = (state != S_IDLE);
      rd_side      = (state == S_HDR) || (state == S_DATA) || (state == S_DRAIN);

      if (abort) begin
         fifo_flush = 1'b1;
         state_nx   = S_IDLE;
         wr_cnt_nx  = '0;
         rd_cnt_nx  = '0;
         hdr_idx_nx = 1'b0;
      end else begin
         if (rd_side) begin
            out_vld    = !fifo_empty;
            out_data   = out_vld ? fifo_rd_data : '0;
            fifo_rd_en = out_vld && out_rdy;
            out_last   = out_vld && (rd_cnt == total_q - ONE);
            if (fifo_rd_en) rd_cnt_nx = rd_cnt + ONE;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  len_nx     = blk_len;
                  total_nx   = {1'b0, blk_len} + HDR_BYTES;
                  wr_cnt_nx  = '0;
                  rd_cnt_nx  = '0;
                  hdr_idx_nx = 1'b0;
                  if (HDR_EN)            state_nx = S_HDR;
                  else if (blk_len == '0) state_nx = S_DONE;
                  else                   state_nx = S_DATA;
               end
            end
            S_HDR: begin
               if (!fifo_almost_full) begin
                  fifo_wr_en   = 1'b1;
                  fifo_wr_data = hdr_idx ? hdr_word[7:0] : hdr_word[15:8];
                  hdr_idx_nx   = !hdr_idx;
                  if (hdr_idx) state_nx = (len_q == '0) ? S_DRAIN : S_DATA;
               end
            end
            S_DATA: begin
               src_rdy = !fifo_almost_full;
               if (src_vld && src_rdy) begin
                  fifo_wr_en   = 1'b1;
                  fifo_wr_data = src_data;
                  wr_cnt_nx    = wr_cnt + ONE;
                  if (wr_cnt + ONE == {1'b0, len_q}) state_nx = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_rd_en && out_last) state_nx = S_DONE;
            end
            S_DONE: begin
               done       = 1'b1;
               state_nx   = S_IDLE;
               wr_cnt_nx  = '0;
               rd_cnt_nx  = '0;
               hdr_idx_nx = 1'b0;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/tdec_wrap_out_sched.md
Name: tdec_wrap_out_sched

Overview:
Output scheduler for the turbo-decoder wrapper's 8-bit byte FIFO. For each code block it prepends a 2-byte length header and admits decoded bytes from the upstream source into the FIFO under almost-full backpressure. It drains the FIFO to a downstream valid/ready byte stream and marks the last byte. Abort handling uses the FIFO flush. It sits between the hard-decision byte packer and the wrapper output port, and owns all FIFO control signals.

Parameters:
LEN_W, 16, width of blk_len (max data bytes per block = 2^LEN_W-1)
HDR_EN, 1, 1 = prepend 2-byte header {blk_len[15:8], blk_len[7:0]}; 0 = no header

Ports:
clk  in  1  clock, 307.2 MHz
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begin block (honoured only in IDLE)
blk_len  in  LEN_W  data byte count; sampled on accepted start
abort  in  1  cancel current block, flush FIFO
src_vld  in  1  upstream byte valid
src_data  in  8  upstream byte
src_rdy  out  1  upstream ready
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  8  FIFO write data
fifo_rd_en  out  1  FIFO read enable (pop)
fifo_rd_data  in  8  FIFO head byte (combinational)
fifo_empty  in  1  FIFO empty
fifo_almost_full  in  1  FIFO above threshold
fifo_flush  out  1  FIFO pointer clear
out_vld  out  1  downstream byte valid
out_data  out  8  downstream byte
out_last  out  1  last byte of block, qualified by out_vld
out_rdy  in  1  downstream ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, block fully delivered

Behaviour:
- Reset: state IDLE, len_q=0, wr_cnt=0, rd_cnt=0, hdr_idx=0. All outputs are 0: src_rdy, fifo_wr_en, fifo_rd_en, fifo_flush, out_vld, out_last, busy, done, fifo_wr_data, out_data.
- total = blk_len + (HDR_EN ? 2 : 0), LEN_W+1 bits, latched with len_q on start. wr_cnt and rd_cnt are LEN_W+1 bits.
- States: IDLE, HDR, DATA, DRAIN, DONE.
- IDLE + start & !abort: HDR if HDR_EN, else DATA. If blk_len==0 and !HDR_EN, go straight to DONE.
- HDR: when !fifo_almost_full, fifo_wr_en=1 and fifo_wr_data = len_q[15:8], then len_q[7:0] on the next write. After the 2nd write go to DATA, or to DRAIN if len_q==0.
- DATA: src_rdy = !fifo_almost_full & !abort. fifo_wr_en = src_vld & src_rdy, fifo_wr_data = src_data, both combinational. On the write of data byte len_q, go to DRAIN. src_rdy=0 in all other states.
- Read side, active in HDR/DATA/DRAIN:
  - out_vld = !fifo_empty, out_data = fifo_rd_data.
  - fifo_rd_en = out_vld & out_rdy; rd_cnt increments on each pop.
  - out_last = out_vld & (rd_cnt == total-1).
- Leave DRAIN for DONE on the pop with out_last. A pop can occur in HDR/DATA; if the final pop coincides with the final write it cannot complete, since the FIFO is non-empty only after the write.
- DONE: done=1 for one cycle, then IDLE. Counters clear.
- Latency: a byte written in cycle n is visible on out_vld in cycle n+1. Header or data writes may coincide with pops in the same cycle.
- out_vld/out_data hold while out_rdy=0 (FIFO head is stable).
- abort, any state, highest priority: fifo_flush=1 for that cycle. fifo_wr_en, fifo_rd_en, out_vld and src_rdy are forced 0. Next state IDLE, counters clear, no done. start in the same cycle as abort is ignored.
- start outside IDLE is ignored. blk_len changes after start have no effect.
- Flow control: the controller never writes while fifo_almost_full=1. FIFO threshold margin is at least 1 entry, so a combinational write on the cycle almost_full rises cannot overflow.
- Reset asserted mid-block returns to IDLE immediately. FIFO contents are cleared by the FIFO's own reset.

Test Plan:
- HDR_EN=1, blk_len=4, src bytes 0xA1..0xA4, out_rdy=1 -> out sequence 0x00,0x04,0xA1,0xA2,0xA3,0xA4; out_last only on 0xA4; done one cycle after the last pop; busy low afterwards.
- blk_len=300, out_rdy=0 until almost_full -> src_rdy drops the same cycle fifo_almost_full rises; no lost or duplicated bytes; with out_rdy toggling 50%, all 302 bytes arrive in order.
- HDR_EN=1, blk_len=0 -> exactly 2 bytes 0x00,0x00, out_last on the 2nd, done pulse.
- abort in DATA after 10 of 20 bytes -> fifo_flush=1 for one cycle, fifo_empty next cycle, out_vld=0, no done; a following start with blk_len=3 delivers a clean 5-byte block.
- start pulsed while busy with a different blk_len -> ignored; current block length is unchanged.
- rst asserted mid-DRAIN -> all outputs 0 asynchronously; state IDLE after release.
